// File: rtl/dp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_pkg: shared constants, opcodes and FSM encoding for dp_executor      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package dp_pkg;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_X_WIDTH      = 8;
    localparam int DEF_Y_WIDTH      = 7;
    localparam int DEF_COLOUR_WIDTH = 3;
    localparam int DEF_OPCODE_WIDTH = 3;
    localparam int DEF_INSTR_WIDTH  = 32;
    localparam int DEF_BLOCK_W      = 4;
    localparam int DEF_BLOCK_H      = 4;

    // Field LSB offsets for the default widths; every format starts with the opcode.
    localparam int OPCODE_LSB = 0;
    localparam int ADDR_LSB   = DEF_OPCODE_WIDTH;
    localparam int DATA_LSB   = ADDR_LSB + DEF_ADDR_WIDTH;
    localparam int X_LSB      = DEF_OPCODE_WIDTH;
    localparam int Y_LSB      = X_LSB + DEF_X_WIDTH;
    localparam int COLOUR_LSB = Y_LSB + DEF_Y_WIDTH;
    localparam int PLOT_LSB   = COLOUR_LSB + DEF_COLOUR_WIDTH;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_MEMREAD  = 3'd1;
    localparam logic [2:0] OP_MEMWRITE = 3'd2;
    localparam logic [2:0] OP_DRAW     = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EXEC       = 3'd1,
        ST_RD_WAIT    = 3'd2,
        ST_RD_CAPTURE = 3'd3,
        ST_DRAW       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_executor_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_executor_if: datapath command handshake (start/instruction/finished) |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface dp_executor_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 8
) ();
    logic                   start;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   finished;
    logic [DATA_WIDTH-1:0]  result;

    modport master (output start, output instruction, input finished, input result);
    modport slave  (input start, input instruction, output finished, output result);
endinterface
`default_nettype wire

// File: rtl/dp_state_ram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_state_ram: single-port synchronous RAM, 1-cycle read, no reset       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module dp_state_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/dp_executor.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dp_executor: responder for datapath commands (NOP/MEMREAD/MEMWRITE/DRAW)|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module dp_executor
    import dp_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int X_WIDTH      = DEF_X_WIDTH,
    parameter int Y_WIDTH      = DEF_Y_WIDTH,
    parameter int COLOUR_WIDTH = DEF_COLOUR_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int BLOCK_W      = DEF_BLOCK_W,
    parameter int BLOCK_H      = DEF_BLOCK_H
) (
    input  logic                    clock,
    input  logic                    resetn,
    dp_executor_if.slave            cmd,
    output logic [X_WIDTH-1:0]      vga_x,
    output logic [Y_WIDTH-1:0]      vga_y,
    output logic [COLOUR_WIDTH-1:0] vga_colour,
    output logic                    vga_plot
);
    localparam int RD_W     = OPCODE_WIDTH + ADDR_WIDTH;
    localparam int WR_W     = RD_W + DATA_WIDTH;
    localparam int DRW_W    = OPCODE_WIDTH + X_WIDTH + Y_WIDTH + COLOUR_WIDTH + 1;
    localparam int USED_W   = max_int(WR_W, DRW_W);
    localparam int A_LSB    = OPCODE_WIDTH;
    localparam int D_LSB    = RD_W;
    localparam int PX_LSB   = OPCODE_WIDTH;
    localparam int PY_LSB   = PX_LSB + X_WIDTH;
    localparam int PC_LSB   = PY_LSB + Y_WIDTH;
    localparam int PLOT_BIT = PC_LSB + COLOUR_WIDTH;
    localparam int CX_W     = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int CY_W     = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    state_t                  state_q, state_d;
    logic                    armed_q, armed_d;
    logic                    finished_q, finished_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [USED_W-1:0]       instr_q, instr_d;
    logic [X_WIDTH-1:0]      vga_x_q, vga_x_d;
    logic [Y_WIDTH-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_WIDTH-1:0] vga_colour_q, vga_colour_d;
    logic                    vga_plot_q, vga_plot_d;
    logic [CX_W-1:0]         cx_q, cx_d;
    logic [CY_W-1:0]         cy_q, cy_d;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [X_WIDTH-1:0]      w_px;
    logic [Y_WIDTH-1:0]      w_py;
    logic [COLOUR_WIDTH-1:0] w_pcolour;
    logic                    w_pplot;
    logic                    w_ram_we;
    logic                    w_last_col;
    logic                    w_last_row;

    assign w_opcode   = instr_q[OPCODE_WIDTH-1:0];
    assign w_addr     = instr_q[A_LSB +: ADDR_WIDTH];
    assign w_wdata    = instr_q[D_LSB +: DATA_WIDTH];
    assign w_px       = instr_q[PX_LSB +: X_WIDTH];
    assign w_py       = instr_q[PY_LSB +: Y_WIDTH];
    assign w_pcolour  = instr_q[PC_LSB +: COLOUR_WIDTH];
    assign w_pplot    = instr_q[PLOT_BIT];
    assign w_last_col = (cx_q == CX_W'(BLOCK_W - 1));
    assign w_last_row = (cy_q == CY_W'(BLOCK_H - 1));

    generate
        if (INSTR_WIDTH > USED_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^cmd.instruction[INSTR_WIDTH-1:USED_W];
        end
    endgenerate

    // Reset gates the write so an uncommitted MEMWRITE is dropped on abort.
    dp_state_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (w_ram_we & resetn),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b1;
            finished_q   <= 1'b1;
            result_q     <= '0;
            instr_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            finished_q   <= finished_d;
            result_q     <= result_d;
            instr_q      <= instr_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q | ~cmd.start;
        finished_d   = finished_q;
        result_d     = result_q;
        instr_d      = instr_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        cx_d         = cx_q;
        cy_d         = cy_q;
        w_ram_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd.start && armed_q) begin
                    instr_d    = cmd.instruction[USED_W-1:0];
                    finished_d = 1'b0;
                    armed_d    = 1'b0;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_opcode == OPCODE_WIDTH'(OP_MEMREAD)) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    result_d = '0;
                    state_d  = ST_DONE;
                    if (w_opcode == OPCODE_WIDTH'(OP_MEMWRITE)) begin
                        w_ram_we = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                result_d = w_rdata;
                state_d  = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_DONE: begin
                finished_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pixel walk shared by the first DRAW pixel (from EXEC) and the rest.
        // Counters always wrap back to (0,0) so the next DRAW starts clean.
        if ((state_q == ST_EXEC && w_opcode == OPCODE_WIDTH'(OP_DRAW)) || state_q == ST_DRAW) begin
            vga_x_d      = w_px + X_WIDTH'(cx_q);
            vga_y_d      = w_py + Y_WIDTH'(cy_q);
            vga_colour_d = w_pcolour;
            vga_plot_d   = w_pplot;
            cx_d         = w_last_col ? '0 : cx_q + CX_W'(1);
            if (w_last_col) begin
                cy_d = w_last_row ? '0 : cy_q + CY_W'(1);
            end
            state_d = (w_last_col && w_last_row) ? ST_DONE : ST_DRAW;
        end
    end

    assign cmd.finished = finished_q;
    assign cmd.result   = result_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_colour   = vga_colour_q;
    assign vga_plot     = vga_plot_q;
endmodule
`default_nettype wire

// File: tb/tb_dp_executor.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dp_executor: self-checking bench with a command-level reference model|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_dp_executor;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [256];
    bit          model_ok  [256];
    logic [17:0] got_px [$];
    logic [17:0] exp_px [$];
    logic        fin_a;

    dp_executor_if #(.INSTR_WIDTH(32), .DATA_WIDTH(8)) cmd ();

    dp_executor dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd        (cmd),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_read(input logic [7:0] a);
        return {21'b0, a, 3'd1};
    endfunction

    function automatic logic [31:0] mk_write(input logic [7:0] d, input logic [7:0] a);
        return {13'b0, d, a, 3'd2};
    endfunction

    function automatic logic [31:0] mk_draw(input logic p, input logic [2:0] c,
                                            input logic [6:0] y, input logic [7:0] x);
        return {10'b0, p, c, y, x, 3'd3};
    endfunction

    // Expected pixel stream: row-major over the block, coordinates wrap.
    task automatic build_exp(input logic p, input logic [2:0] c,
                             input logic [6:0] y, input logic [7:0] x);
        logic [7:0] ex;
        logic [6:0] ey;
        exp_px.delete();
        if (p) begin
            for (int r = 0; r < 4; r++) begin
                for (int q = 0; q < 4; q++) begin
                    ex = x + 8'(q);
                    ey = y + 7'(r);
                    exp_px.push_back({ex, ey, c});
                end
            end
        end
    endtask

    function automatic bit px_match();
        if (got_px.size() != exp_px.size()) return 1'b0;
        foreach (got_px[i]) if (got_px[i] !== exp_px[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Issues one command, holding start for 'hold' edges; optionally re-raises
    // start with another word at cycle intr_k while busy. lat = -1 on timeout.
    task automatic exec_cmd(input logic [31:0] ins, input int hold, input int intr_k,
                            input logic [31:0] intr_ins, output int lat, output int busy);
        got_px.delete();
        lat = -1;
        @(negedge clock);
        cmd.start       = 1'b1;
        cmd.instruction = ins;
        @(posedge clock); #1;
        fin_a = cmd.finished;
        busy  = (cmd.finished !== 1'b1) ? 1 : 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == hold) cmd.start = 1'b0;
            if (intr_k != 0 && k == intr_k) begin
                cmd.start       = 1'b1;
                cmd.instruction = intr_ins;
            end
            if (intr_k != 0 && k == intr_k + 2) cmd.start = 1'b0;
            @(posedge clock); #1;
            if (cmd.finished !== 1'b1) busy++;
            if (vga_plot === 1'b1) got_px.push_back({vga_x, vga_y, vga_colour});
            if (cmd.finished === 1'b1 && lat < 0) lat = k;
            if (lat >= 0 && k >= hold && (intr_k == 0 || k > intr_k + 2)) break;
        end
        cmd.start = 1'b0;
    endtask

    task automatic test_reset();
        cmd.start       = 1'b0;
        cmd.instruction = '0;
        resetn          = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (cmd.finished !== 1'b1) begin errors++; $display("FAIL reset_finished got %b want 1", cmd.finished); end
        checks++;
        if (cmd.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", cmd.result); end
        checks++;
        if (vga_plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", vga_plot); end
        checks++;
        if ({vga_x, vga_y, vga_colour} !== 18'd0) begin
            errors++; $display("FAIL reset_vga got %h/%h/%h want 0/0/0", vga_x, vga_y, vga_colour);
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, busy;
        exec_cmd(mk_write(8'h5A, 8'h10), 2, 0, '0, lat, busy);
        model_mem[8'h10] = 8'h5A; model_ok[8'h10] = 1'b1;
        checks++;
        if (fin_a !== 1'b0) begin errors++; $display("FAIL write_busy_after_accept got %b want 0", fin_a); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
        exec_cmd(mk_read(8'h10), 2, 0, '0, lat, busy);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d want 3", lat); end
        checks++;
        if (cmd.result !== 8'h5A) begin errors++; $display("FAIL read_result got %h want 5a", cmd.result); end
    endtask

    task automatic test_read_other();
        int lat, busy;
        exec_cmd(mk_write(8'h33, 8'h11), 2, 0, '0, lat, busy);
        model_mem[8'h11] = 8'h33; model_ok[8'h11] = 1'b1;
        exec_cmd(mk_read(8'h11), 2, 0, '0, lat, busy);
        checks++;
        if (cmd.result !== model_mem[8'h11]) begin errors++; $display("FAIL read_11 got %h want %h", cmd.result, model_mem[8'h11]); end
        exec_cmd(mk_read(8'h10), 2, 0, '0, lat, busy);
        checks++;
        if (cmd.result !== model_mem[8'h10]) begin errors++; $display("FAIL read_10 got %h want %h", cmd.result, model_mem[8'h10]); end
    endtask

    task automatic test_draw();
        int lat, busy;
        exec_cmd(mk_draw(1'b1, 3'b100, 7'd20, 8'd10), 2, 0, '0, lat, busy);
        build_exp(1'b1, 3'b100, 7'd20, 8'd10);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL draw_latency got %0d want 17", lat); end
        checks++;
        if (got_px.size() !== 16) begin errors++; $display("FAIL draw_plot_count got %0d want 16", got_px.size()); end
        checks++;
        if (px_match() !== 1'b1) begin errors++; $display("FAIL draw_pixels got %0d px want %0d px in row-major order", got_px.size(), exp_px.size()); end
        checks++;
        if (cmd.result !== 8'h00) begin errors++; $display("FAIL draw_result got %h want 00", cmd.result); end
        exec_cmd(mk_draw(1'b1, 3'b011, 7'd126, 8'd254), 2, 0, '0, lat, busy);
        build_exp(1'b1, 3'b011, 7'd126, 8'd254);
        checks++;
        if (px_match() !== 1'b1) begin errors++; $display("FAIL draw_wrap got %0d px want %0d px", got_px.size(), exp_px.size()); end
        exec_cmd(mk_draw(1'b0, 3'b111, 7'd3, 8'd7), 2, 0, '0, lat, busy);
        checks++;
        if (lat !== 17 || got_px.size() !== 0) begin
            errors++; $display("FAIL draw_noplot got lat %0d plots %0d want lat 17 plots 0", lat, got_px.size());
        end
    endtask

    task automatic test_handshake();
        int lat, busy;
        exec_cmd({29'h1ABCDE, 3'd0}, 10, 0, '0, lat, busy);
        checks++;
        if (lat !== 2 || busy !== 2) begin
            errors++; $display("FAIL held_start got lat %0d busy %0d want lat 2 busy 2", lat, busy);
        end
        exec_cmd(mk_draw(1'b1, 3'b001, 7'd30, 8'd100), 2, 5, mk_write(8'hEE, 8'h10), lat, busy);
        build_exp(1'b1, 3'b001, 7'd30, 8'd100);
        checks++;
        if (lat !== 17 || px_match() !== 1'b1) begin
            errors++; $display("FAIL busy_start_draw got lat %0d px %0d want lat 17 px 16", lat, got_px.size());
        end
        exec_cmd(mk_read(8'h10), 2, 0, '0, lat, busy);
        checks++;
        if (cmd.result !== model_mem[8'h10]) begin errors++; $display("FAIL busy_start_ignored got %h want %h", cmd.result, model_mem[8'h10]); end
        exec_cmd({29'h0F0F0F0, 3'd6}, 2, 0, '0, lat, busy);
        checks++;
        if (lat !== 2 || cmd.result !== 8'h00) begin
            errors++; $display("FAIL opcode6_nop got lat %0d result %h want lat 2 result 00", lat, cmd.result);
        end
    endtask

    task automatic test_reset_mid_draw();
        int lat, busy;
        @(negedge clock);
        cmd.start       = 1'b1;
        cmd.instruction = mk_draw(1'b1, 3'b010, 7'd5, 8'd40);
        @(posedge clock); #1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) cmd.start = 1'b0;
            @(posedge clock); #1;
        end
        checks++;
        if (vga_plot !== 1'b1 || cmd.finished !== 1'b0) begin
            errors++; $display("FAIL mid_draw_active got plot %b fin %b want plot 1 fin 0", vga_plot, cmd.finished);
        end
        resetn = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (vga_plot !== 1'b0 || cmd.finished !== 1'b1) begin
            errors++; $display("FAIL mid_draw_abort got plot %b fin %b want plot 0 fin 1", vga_plot, cmd.finished);
        end
        @(negedge clock);
        resetn = 1'b1;
        exec_cmd(mk_read(8'h11), 2, 0, '0, lat, busy);
        checks++;
        if (lat !== 3 || cmd.result !== model_mem[8'h11]) begin
            errors++; $display("FAIL post_reset_read got lat %0d data %h want lat 3 data %h", lat, cmd.result, model_mem[8'h11]);
        end
    endtask

    task automatic test_random();
        int lat, busy, sel, exp_lat;
        logic [7:0] a, d, ex_res, x;
        logic [6:0] y;
        logic [2:0] c;
        logic p;
        logic [31:0] ins;
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 9);
            a   = 8'h40 + 8'($urandom_range(0, 7));
            exp_px.delete();
            if (sel <= 2 || (sel <= 5 && !model_ok[a])) begin
                d = 8'($urandom);
                ins = mk_write(d, a);
                model_mem[a] = d; model_ok[a] = 1'b1;
                exp_lat = 2; ex_res = 8'h00;
            end else if (sel <= 5) begin
                ins = mk_read(a);
                exp_lat = 3; ex_res = model_mem[a];
            end else if (sel <= 7) begin
                x = 8'($urandom); y = 7'($urandom); c = 3'($urandom); p = 1'($urandom);
                ins = mk_draw(p, c, y, x);
                build_exp(p, c, y, x);
                exp_lat = 17; ex_res = 8'h00;
            end else begin
                ins = $urandom;
                ins[2:0] = (sel == 8) ? 3'd0 : 3'(4 + $urandom_range(0, 3));
                exp_lat = 2; ex_res = 8'h00;
            end
            exec_cmd(ins, 2, 0, '0, lat, busy);
            checks++;
            if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d] ins %h got %0d want %0d", n, ins, lat, exp_lat); end
            checks++;
            if (cmd.result !== ex_res) begin errors++; $display("FAIL rand_result[%0d] ins %h got %h want %h", n, ins, cmd.result, ex_res); end
            checks++;
            if (px_match() !== 1'b1) begin errors++; $display("FAIL rand_pixels[%0d] ins %h got %0d px want %0d px", n, ins, got_px.size(), exp_px.size()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_read_other();
        test_draw();
        test_handshake();
        test_reset_mid_draw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
